// File: rtl/bcd_counter_7seg.sv
// DIGITS-wide cascaded BCD up/down counter with prescaler, wrap pulse and active-low 7-seg decode.
// Optional leading-zero blanking when BCD_COUNTER_7SEG_BLANK_EN is defined.

module bcd_digit (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       up_down,
  output logic [3:0] digit,
  output logic       term
);
  // term: this digit is at its rollover value for the current direction
  assign term = up_down ? (digit == 4'd9) : (digit == 4'd0);

  always_ff @(posedge clock) begin
    if (reset || clear)
      digit <= 4'd0;
    else if (en)
      digit <= up_down ? (term ? 4'd0 : digit + 4'd1)
                       : (term ? 4'd9 : digit - 4'd1);
  end
endmodule

module bcd_counter_7seg #(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 50000000,
  parameter int PRESCALE_W = 26
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ativador,
  input  logic                  up_down,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  step,
  output logic                  clockOut
);
  localparam logic [PRESCALE_W-1:0] PRE_MAX = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] pre;
  logic                  tick;
  logic [DIGITS-1:0]     term;
  logic [DIGITS-1:0]     en;
  logic                  wrap;

  assign tick = ativador && (pre == PRE_MAX);

  // Carry/borrow reaches digit k only if every lower digit is at its rollover value
  always_comb begin
    en   = '0;
    wrap = tick;
    for (int k = 0; k < DIGITS; k++) begin
      en[k] = wrap;
      wrap  = wrap & term[k];
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      pre      <= '0;
      step     <= 1'b0;
      clockOut <= 1'b0;
    end else begin
      if (ativador) pre <= tick ? '0 : pre + 1'b1;
      step     <= tick;
      clockOut <= wrap;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clock   (clock),
      .reset   (reset),
      .clear   (clear),
      .en      (en[g]),
      .up_down (up_down),
      .digit   (bcd[4*g +: 4]),
      .term    (term[g])
    );
  end

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'b0000001;
      4'd1:    dec7 = 7'b1001111;
      4'd2:    dec7 = 7'b0010010;
      4'd3:    dec7 = 7'b0000110;
      4'd4:    dec7 = 7'b1001100;
      4'd5:    dec7 = 7'b0100100;
      4'd6:    dec7 = 7'b0100000;
      4'd7:    dec7 = 7'b0001111;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0000100;
      default: dec7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
`ifdef BCD_COUNTER_7SEG_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    seg = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      seg[7*k +: 7] = dec7(bcd[4*k +: 4]);
`ifdef BCD_COUNTER_7SEG_BLANK_EN
      // lead stays set while this digit and all above it are zero
      lead = lead & (bcd[4*k +: 4] == 4'd0);
      if (k > 0 && lead) seg[7*k +: 7] = 7'b1111111;
`endif
    end
  end
endmodule
